ps2_keyboard_rx: RTL and testbench

Keyboard front end for the simple CPU. Receives device-to-host PS/2 frames on the raw ps2_clk/ps2_data pins and checks framing and parity. Delivers each valid scan-code byte to the register file's keyboard input as gpi[7:0] with a single-cycle gpi_we strobe. The register file loads the byte into R11 and sets the F flag on that strobe.

---
 rtl/ps2_keyboard_rx.sv | 163 ++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: synchronizes and deglitches the pins, deframes 11-bit frames.
// Optional macro PS2_BREAK_FILTER_EN suppresses F0-prefixed key-release codes.
module ps2_keyboard_rx #(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned FILTER_LEN     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] gpi,
   output logic       gpi_we,
   output logic       frame_err
);

   localparam int unsigned FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

   logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
   logic                   filt_q, filt_d;
   logic [FCNT_W-1:0]      filt_cnt_q, filt_cnt_d;
   logic                   fall_q, fall_d;
   state_e                 state_q, state_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic [7:0]             shift_q, shift_d;
   logic                   parity_q, parity_d;
   logic [TCNT_W-1:0]      to_cnt_q, to_cnt_d;
   logic [7:0]             gpi_q, gpi_d;
   logic                   gpi_we_q, gpi_we_d;
   logic                   frame_err_q, frame_err_d;
`ifdef PS2_BREAK_FILTER_EN
   logic                   break_q, break_d;
`endif

   logic clk_s, data_s;
   assign clk_s  = clk_sync_q[SYNC_STAGES-1];
   assign data_s = data_sync_q[SYNC_STAGES-1];

   always_comb begin
      filt_d      = filt_q;
      filt_cnt_d  = '0;
      fall_d      = 1'b0;
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      parity_d    = parity_q;
      to_cnt_d    = to_cnt_q;
      gpi_d       = gpi_q;
      gpi_we_d    = 1'b0;
      frame_err_d = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
      break_d     = break_q;
`endif

      // Accept a new clock level only after FILTER_LEN consecutive differing samples
      if (clk_s != filt_q) begin
         if (filt_cnt_q == FCNT_W'(FILTER_LEN - 1)) begin
            filt_d = clk_s;
            fall_d = filt_q & ~clk_s;
         end else begin
            filt_cnt_d = filt_cnt_q + FCNT_W'(1);
         end
      end

      // A fall always beats a coincident timeout
      if (state_q == IDLE || fall_q) begin
         to_cnt_d = '0;
      end else if (to_cnt_q == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
         to_cnt_d    = '0;
         state_d     = IDLE;
         frame_err_d = 1'b1;
      end else begin
         to_cnt_d = to_cnt_q + TCNT_W'(1);
      end

      if (fall_q) begin
         case (state_q)
            IDLE: begin
               if (!data_s) begin
                  state_d   = DATA;
                  bit_cnt_d = 3'd0;
               end
            end
            DATA: begin
               shift_d   = {data_s, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: begin
               parity_d = data_s;
               state_d  = STOP;
            end
            STOP: begin
               state_d = IDLE;
               if (data_s && (^{shift_q, parity_q})) begin
`ifdef PS2_BREAK_FILTER_EN
                  if (break_q) begin
                     break_d = 1'b0;
                  end else if (shift_q == 8'hF0) begin
                     break_d = 1'b1;
                  end else begin
                     gpi_d    = shift_q;
                     gpi_we_d = 1'b1;
                  end
`else
                  gpi_d    = shift_q;
                  gpi_we_d = 1'b1;
`endif
               end else begin
                  frame_err_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         clk_sync_q  <= '1;
         data_sync_q <= '1;
         filt_q      <= 1'b1;
         filt_cnt_q  <= '0;
         fall_q      <= 1'b0;
         state_q     <= IDLE;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 8'h00;
         parity_q    <= 1'b0;
         to_cnt_q    <= '0;
         gpi_q       <= 8'h00;
         gpi_we_q    <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
         break_q     <= 1'b0;
`endif
      end else begin
         clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
         data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
         filt_q      <= filt_d;
         filt_cnt_q  <= filt_cnt_d;
         fall_q      <= fall_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         parity_q    <= parity_d;
         to_cnt_q    <= to_cnt_d;
         gpi_q       <= gpi_d;
         gpi_we_q    <= gpi_we_d;
         frame_err_q <= frame_err_d;
`ifdef PS2_BREAK_FILTER_EN
         break_q     <= break_d;
`endif
      end
   end

   assign gpi       = gpi_q;
   assign gpi_we    = gpi_we_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: directed and random PS/2 frames against a frame-level reference model.
module tb_ps2_keyboard_rx;

   localparam int SYNC  = 2;
   localparam int FILT  = 4;
   localparam int TMO   = 1000;
   localparam int HP    = 20;
   localparam int BOUND = SYNC + FILT + 2;
`ifdef PS2_BREAK_FILTER_EN
   localparam bit BRK = 1'b1;
`else
   localparam bit BRK = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] gpi;
   logic       gpi_we;
   logic       frame_err;

   ps2_keyboard_rx #(.SYNC_STAGES(SYNC), .FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
      .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .gpi(gpi), .gpi_we(gpi_we), .frame_err(frame_err)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // Output monitor, sampled on the falling edge
   int we_cnt = 0, err_cnt = 0, both_cnt = 0;
   int last_we_cyc = 0, last_err_cyc = 0;
   logic [7:0] got_q[$];
   always @(negedge clock) begin
      if (gpi_we) begin
         we_cnt++;
         last_we_cyc = cyc;
         got_q.push_back(gpi);
      end
      if (frame_err) begin
         err_cnt++;
         last_err_cyc = cyc;
      end
      if (gpi_we && frame_err) both_cnt++;
   end

   int n_cmp = 0, n_bad = 0;
   int fall_cyc = 0;
   int exp_we = 0, exp_err = 0;
   logic [7:0] exp_gpi = 8'h00;
   bit pend = 1'b0;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clock);
   endtask

   // One PS/2 bit; g>0 adds a g-cycle glitch in both the high and low phases
   task automatic send_bit(input logic b, input int g);
      ps2_data = b;
      wait_clks(2);
      if (g > 0) begin ps2_clk = 1'b0; wait_clks(g); ps2_clk = 1'b1; end
      wait_clks(HP/2 - 2 - g);
      ps2_clk  = 1'b0;
      fall_cyc = cyc;
      wait_clks(8);
      if (g > 0) begin ps2_clk = 1'b1; wait_clks(g); ps2_clk = 1'b0; end
      wait_clks(HP - 8 - g);
      ps2_clk = 1'b1;
      wait_clks(HP/2);
   endtask

   task automatic frame(input string tag, input logic [7:0] b, input bit bad_par,
                        input bit bad_stop, input int g);
      logic par;
      bit ok;
      int lat;
      par = ~(^b) ^ bad_par;
      send_bit(1'b0, g);
      for (int i = 0; i < 8; i++) send_bit(b[i], g);
      send_bit(par, g);
      send_bit(~bad_stop, g);
      wait_clks(30);
      ok = !bad_par && !bad_stop;
      if (!ok) exp_err++;
      else if (BRK && pend) pend = 1'b0;
      else if (BRK && b == 8'hF0) pend = 1'b1;
      else begin exp_we++; exp_gpi = b; end
      check({tag, "_we_cnt"}, we_cnt, exp_we);
      check({tag, "_err_cnt"}, err_cnt, exp_err);
      check({tag, "_gpi"}, int'(gpi), int'(exp_gpi));
      if (!ok) begin
         lat = last_err_cyc - fall_cyc;
         check({tag, "_err_lat_ok"}, int'(lat >= 1 && lat <= BOUND), 1);
      end else if (exp_we > 0 && last_we_cyc > fall_cyc) begin
         lat = last_we_cyc - fall_cyc;
         check({tag, "_we_lat_ok"}, int'(lat >= 1 && lat <= BOUND), 1);
      end
   endtask

   initial begin
      wait_clks(3);
      check("rst_gpi", int'(gpi), 0);
      check("rst_we", int'(gpi_we), 0);
      check("rst_err", int'(frame_err), 0);
      reset = 1'b1;
      wait_clks(20);

      frame("a_make", 8'h1C, 1'b0, 1'b0, 0);
      frame("bad_par", 8'h1C, 1'b1, 1'b0, 0);
      frame("bad_stop", 8'h3B, 1'b0, 1'b1, 0);

      // Partial frame then silence: timeout abandons it
      for (int i = 0; i < 5; i++) send_bit(1'b0, 0);
      wait_clks(TMO + 200);
      exp_err++;
      check("tmo_err_cnt", err_cnt, exp_err);
      check("tmo_we_cnt", we_cnt, exp_we);
      check("tmo_gpi", int'(gpi), int'(exp_gpi));
      frame("after_tmo", 8'h29, 1'b0, 1'b0, 0);

      frame("glitch1", 8'h5A, 1'b0, 1'b0, 1);
      frame("glitch3", 8'h5A, 1'b0, 1'b0, 3);
      frame("e0_prefix", 8'hE0, 1'b0, 1'b0, 0);

      frame("seq_1c", 8'h1C, 1'b0, 1'b0, 0);
      frame("seq_f0", 8'hF0, 1'b0, 1'b0, 0);
      frame("seq_1c_rel", 8'h1C, 1'b0, 1'b0, 0);

      for (int n = 0; n < 14; n++) begin
         logic [7:0] rb;
         bit bp, bs;
         rb = 8'($urandom);
         if ($urandom_range(0, 5) == 0) rb = 8'hF0;
         bp = ($urandom_range(0, 5) == 0);
         bs = !bp && ($urandom_range(0, 7) == 0);
         frame($sformatf("rnd%0d", n), rb, bp, bs, int'($urandom_range(0, 3)));
      end

      // Reset in the middle of a frame
      for (int i = 0; i < 5; i++) send_bit(1'b1 ^ (i == 0), 0);
      reset = 1'b0;
      wait_clks(2);
      check("midrst_gpi", int'(gpi), 0);
      check("midrst_we", int'(gpi_we), 0);
      check("midrst_err", int'(frame_err), 0);
      exp_gpi = 8'h00;
      pend    = 1'b0;
      wait_clks(5);
      reset = 1'b1;
      wait_clks(TMO + 200);
      check("postrst_we_cnt", we_cnt, exp_we);
      check("postrst_err_cnt", err_cnt, exp_err);
      frame("after_rst", 8'h66, 1'b0, 1'b0, 0);

      check("never_both", both_cnt, 0);
      check("strobe_log_len", got_q.size(), exp_we);
      check("last_logged", int'(got_q[$]), 8'h66);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #20ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
